// File: rtl/uart_tx_fifo_param.sv
// UART transmitter with a word FIFO: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Frame configuration and bit period are captured when a word is popped.
module uart_tx_fifo_param #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PRESCALE_W = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     p_data,
  input  logic                  data_valid,
  output logic                  ready,
  input  logic                  par_en,
  input  logic                  par_type,
  input  logic                  stop2,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned IW = 4;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state, state_n;
  logic [DATA_W-1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count, count_n;
  logic                    push, pop;
  logic [DATA_W-1:0]       sh, sh_n;
  logic [PRESCALE_W-1:0]   per, per_n, cnt, cnt_n;
  logic [IW-1:0]           idx, idx_n;
  logic                    par_en_q, par_en_n, par_bit_q, par_bit_n, stop2_q, stop2_n;
  logic                    tx_n;

  assign push    = data_valid && ready;
  assign count_n = count + CW'(push) - CW'(pop);

  // FIFO storage needs no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= p_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      sh        <= '0;
      per       <= '0;
      cnt       <= '0;
      idx       <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_out    <= 1'b1;
      busy      <= 1'b0;
      ready     <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_n;
      sh        <= sh_n;
      per       <= per_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      par_en_q  <= par_en_n;
      par_bit_q <= par_bit_n;
      stop2_q   <= stop2_n;
      tx_out    <= tx_n;
      busy      <= (state_n != IDLE) || (count_n != '0);
      ready     <= (count_n != CW'(FIFO_DEPTH));
      overflow  <= data_valid && !ready;
    end
  end

  // Next-state and datapath; each bit ends when the down-counter reaches zero
  always_comb begin
    logic load;
    state_n   = state;
    sh_n      = sh;
    per_n     = per;
    cnt_n     = cnt;
    idx_n     = idx;
    par_en_n  = par_en_q;
    par_bit_n = par_bit_q;
    stop2_n   = stop2_q;
    tx_n      = tx_out;
    pop       = 1'b0;
    load      = 1'b0;

    if (state != IDLE && cnt != '0) cnt_n = cnt - PRESCALE_W'(1);

    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (count != '0) load = 1'b1;
      end
      START: if (cnt == '0) begin
        state_n = DATA;
        tx_n    = sh[0];
        idx_n   = '0;
        cnt_n   = per - PRESCALE_W'(1);
      end
      DATA: if (cnt == '0) begin
        cnt_n = per - PRESCALE_W'(1);
        if (idx == IW'(DATA_W - 1)) begin
          idx_n = '0;
          if (par_en_q) begin
            state_n = PARITY;
            tx_n    = par_bit_q;
          end else begin
            state_n = STOP;
            tx_n    = 1'b1;
          end
        end else begin
          idx_n = idx + IW'(1);
          sh_n  = sh >> 1;
          tx_n  = sh[1];
        end
      end
      PARITY: if (cnt == '0) begin
        state_n = STOP;
        tx_n    = 1'b1;
        idx_n   = '0;
        cnt_n   = per - PRESCALE_W'(1);
      end
      STOP: if (cnt == '0) begin
        if (stop2_q && idx == '0) begin
          idx_n = IW'(1);
          cnt_n = per - PRESCALE_W'(1);
        end else if (count != '0) begin
          load = 1'b1;
        end else begin
          state_n = IDLE;
          tx_n    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Pop the head word and capture the frame configuration with it
    if (load) begin
      pop       = 1'b1;
      state_n   = START;
      tx_n      = 1'b0;
      sh_n      = mem[rd_ptr];
      per_n     = (prescale == '0) ? PRESCALE_W'(1) : prescale;
      cnt_n     = per_n - PRESCALE_W'(1);
      idx_n     = '0;
      par_en_n  = par_en;
      par_bit_n = (^mem[rd_ptr]) ^ par_type;
      stop2_n   = stop2;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: queue-based line model checked every cycle, plus literal frame checks.
module tb_uart_tx_fifo_param;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  p_data = '0;
  logic        data_valid = 1'b0;
  logic        par_en = 1'b0;
  logic        par_type = 1'b0;
  logic        stop2 = 1'b0;
  logic [15:0] prescale = 16'd4;
  logic        ready, tx_out, busy, overflow;

  int checks = 0;
  int failures = 0;

  uart_tx_fifo_param #(.DATA_W(8), .PRESCALE_W(16), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid), .ready(ready),
    .par_en(par_en), .par_type(par_type), .stop2(stop2), .prescale(prescale),
    .tx_out(tx_out), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of pending words and a per-cycle list of line levels for the frame in flight
  logic [7:0] mq[$];
  bit         line[$];
  bit         m_tx = 1'b1, m_busy = 1'b0, m_ready = 1'b1, m_ov = 1'b0, m_push = 1'b0;

  task automatic start_frame(input logic [7:0] w);
    int p;
    bit b[$];
    p = (prescale == 16'd0) ? 1 : int'(prescale);
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(w[i]);
    if (par_en) b.push_back((^w) ^ par_type);
    b.push_back(1'b1);
    if (stop2) b.push_back(1'b1);
    foreach (b[k]) for (int j = 0; j < p; j++) line.push_back(b[k]);
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      mq.delete(); line.delete();
      m_tx = 1'b1; m_busy = 1'b0; m_ready = 1'b1; m_ov = 1'b0;
    end else begin
      m_ov   = data_valid && !m_ready;
      m_push = data_valid && m_ready;
      if (line.size() > 0) line.delete(0);
      if (line.size() == 0 && mq.size() > 0) start_frame(mq.pop_front());
      if (m_push) mq.push_back(p_data);
      m_tx    = (line.size() > 0) ? line[0] : 1'b1;
      m_busy  = (line.size() > 0) || (mq.size() > 0);
      m_ready = (mq.size() < DEPTH);
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("model_tx", tx_out, m_tx);
      chk("model_busy", busy, m_busy);
      chk("model_ready", ready, m_ready);
      chk("model_overflow", overflow, m_ov);
    end
  end

  task automatic write(input logic [7:0] w);
    p_data = w;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  // bits[0] is the start bit; called on the negedge right after the write edge
  task automatic check_frame(input logic [15:0] bits, input int n, input int p, input int newp);
    chk("pre_start_tx", tx_out, 1);
    @(negedge clk);
    for (int b = 0; b < n; b++) begin
      chk($sformatf("frame_bit%0d", b), tx_out, bits[b]);
      if (b == 0 && newp >= 0) prescale = 16'(newp);
      repeat (p) @(negedge clk);
    end
    chk("end_tx", tx_out, 1);
    chk("end_busy", busy, 0);
  endtask

  task automatic wait_idle(input int exp, input string name);
    int c = 0;
    while (busy && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk(name, c, exp);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_tx", tx_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 1);
    chk("rst_overflow", overflow, 0);

    // basic frame 0xA5, P=4
    write(8'hA5);
    chk("busy_on_write", busy, 1);
    check_frame({6'b0, 1'b1, 8'hA5, 1'b0}, 10, 4, -1);

    // parity variants
    par_en = 1'b1; par_type = 1'b0;
    write(8'hA5); check_frame({5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 4, -1);
    par_type = 1'b1;
    write(8'hA5); check_frame({5'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, 4, -1);
    par_type = 1'b0;
    write(8'h01); check_frame({5'b0, 1'b1, 1'b1, 8'h01, 1'b0}, 11, 4, -1);
    par_type = 1'b1;
    write(8'h01); check_frame({5'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11, 4, -1);
    par_en = 1'b0; par_type = 1'b0;

    // two stop bits, prescale 0, prescale changed mid-frame
    stop2 = 1'b1; prescale = 16'd0;
    write(8'hFF); check_frame({5'b0, 2'b11, 8'hFF, 1'b0}, 11, 1, 8);
    stop2 = 1'b0;

    // FIFO fill and overflow
    prescale = 16'd16;
    for (int i = 0; i < 6; i++) begin
      p_data = 8'(8'h10 + i);
      data_valid = 1'b1;
      @(negedge clk);
      if (i == 3) chk("ready_before_full", ready, 1);
      if (i == 4) chk("ready_full", ready, 0);
      if (i == 5) chk("overflow_pulse", overflow, 1);
    end
    data_valid = 1'b0;
    @(negedge clk);
    chk("overflow_clear", overflow, 0);
    wait_idle(795, "fill_busy_span");

    // reset in the middle of data bit 3 with two words queued
    prescale = 16'd4;
    write(8'h3C); write(8'h11); write(8'h22);
    repeat (16) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    chk("pre_reset_bit3", tx_out, 1);
    #2 rst = 1'b0;
    #1;
    chk("reset_tx", tx_out, 1);
    chk("reset_busy", busy, 0);
    chk("reset_ready", ready, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_reset_tx", tx_out, 1);
    chk("post_reset_busy", busy, 0);

    // config latching: par_en raised during the first frame applies to the second
    prescale = 16'd2; par_en = 1'b0; par_type = 1'b0;
    write(8'h01); write(8'h01);
    par_en = 1'b1;
    wait_idle(42, "latch_busy_span");
    par_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_param.md
Name: uart_tx_fifo_param

Overview:
Parametrised next-generation UART transmitter. It accepts parallel words into an internal FIFO and serialises each word LSB-first. Each frame is start bit, DATA_W data bits, optional parity, then one or two stop bits. Bit period is set at run time by a prescale input. It replaces the fixed 8-bit, one-word transmitter in the UART TX path and drives the serial line directly.

Parameters:
DATA_W, 8, data bits per frame (5..9 legal)
PRESCALE_W, 16, width of prescale input
FIFO_DEPTH, 4, words buffered (power of two, >=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
p_data  input  DATA_W  word to transmit
data_valid  input  1  write strobe; word accepted when data_valid && ready
ready  output  1  FIFO not full
par_en  input  1  1 = parity bit inserted
par_type  input  1  0 = even, 1 = odd
stop2  input  1  1 = two stop bits, 0 = one
prescale  input  PRESCALE_W  clk cycles per bit; 0 treated as 1
tx_out  output  1  serial line, idle high
busy  output  1  frame in progress or FIFO non-empty
overflow  output  1  one-cycle pulse: data_valid while !ready, word dropped

Behaviour:
- Reset (rst=0, asynchronous): tx_out=1, busy=0, ready=1, overflow=0, FIFO emptied, FSM=IDLE, bit/prescale counters=0.
- Reset mid-frame aborts the frame: tx_out returns high immediately and the frame is not resumed after reset release.
- FIFO write: on a rising edge with data_valid && ready, p_data is pushed.
- FIFO full: ready=0 (registered, from occupancy). A data_valid while full drops the word and pulses overflow for exactly that cycle.
- Simultaneous push and pop when full: legal only if ready=1 in that cycle, i.e. ready does not look ahead.
- FSM states: IDLE -> START -> DATA -> (PARITY if par_en) -> STOP -> IDLE, or STOP -> START when the FIFO is non-empty.
- Frame start: in IDLE with FIFO non-empty, the FSM pops the head word on the next edge. On that pop it latches data, par_en, par_type, stop2 and prescale. Config changes mid-frame have no effect.
- Latency: a word written at edge N into an empty FIFO while idle drives tx_out=0 (start bit) from edge N+1.
- Bit timing: each bit is held for max(prescale,1) clk cycles, counted by a down-counter.
- Frame length in cycles = P*(1+DATA_W+par_en+1+stop2), where P = max(prescale,1).
- DATA: bit i of the latched word is sent in data slot i (LSB first).
- Parity bit: even = XOR of data bits; odd = its inverse.
- STOP: tx_out=1 for 1 or 2 bit periods.
- Back-to-back frames: if the FIFO is non-empty at the end of the last stop bit, the next start bit begins on the following cycle, with no idle gap.
- busy: 1 while FSM != IDLE or FIFO non-empty. It falls on the cycle after the last stop bit completes when the FIFO is empty.
- tx_out is driven from a register; no combinational path from inputs.

Test Plan:
- Basic frame: DATA_W=8, prescale=4, par_en=0, stop2=0, write 0xA5 -> tx_out bits 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each 4 cycles; busy high 40 cycles; start bit 1 cycle after write edge.
- Parity: 0xA5 with par_en=1 -> par_type=0 gives parity bit 0, par_type=1 gives parity bit 1; frame 11 bits (44 cycles). Repeat with 0x01 -> even parity 1, odd 0.
- Stop bits / prescale 0: stop2=1, prescale=0, write 0xFF -> 11 bits of 1 cycle each, tx_out low only during the start cycle; prescale changed mid-frame to 8 does not stretch the current frame.
- FIFO fill/overflow: FIFO_DEPTH=4, prescale=16, assert data_valid 6 consecutive cycles with words 0x10..0x15 -> first word popped after 1 cycle; ready falls after the 5th write; 0x15 dropped with a 1-cycle overflow pulse; 0x10..0x14 then sent back-to-back with no idle cycles; busy continuous.
- Reset mid-frame: reset during data bit 3 of 0x3C with 2 words queued -> tx_out=1, busy=0, ready=1 immediately; after release, line stays idle and no queued word is sent.
- Config latching: par_en toggled 0->1 during a frame -> current frame has no parity bit; the next frame popped after the change carries one.
